// File: rtl/ext_mem_reader_if.sv
// rtl/ext_mem_reader_if.sv - OBI read-master bus and output stream bundle for ext_mem_reader
interface ext_mem_reader_if;
  logic        mst_req_o;
  logic        mst_gnt_i;
  logic [31:0] mst_addr_o;
  logic        mst_we_o;
  logic [3:0]  mst_be_o;
  logic [31:0] mst_wdata_o;
  logic        mst_rvalid_i;
  logic [31:0] mst_rdata_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;

  modport master (
    output mst_req_o, mst_addr_o, mst_we_o, mst_be_o, mst_wdata_o, data_o, valid_o,
    input  mst_gnt_i, mst_rvalid_i, mst_rdata_i, ready_i
  );

  modport slave (
    input  mst_req_o, mst_addr_o, mst_we_o, mst_be_o, mst_wdata_o, data_o, valid_o,
    output mst_gnt_i, mst_rvalid_i, mst_rdata_i, ready_i
  );
endinterface

// File: rtl/ext_mem_reader.sv
// rtl/ext_mem_reader.sv - OBI block reader streaming words through a credit-limited FIFO; optional EXT_MEM_READER_CHECKSUM_EN
module ext_mem_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  ext_mem_reader_if.master     bus
`ifdef EXT_MEM_READER_CHECKSUM_EN
  ,
  output logic [31:0]          checksum_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [31:0]          addr_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic [CW-1:0]        outst_q;
  logic [CW-1:0]        count_q;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [31:0]          mem_q [FIFO_DEPTH];
  logic                 done_q;

  logic req, gnt_fire, push, pop, valid, credit_ok, drain_done, start_ok;

  // Outstanding requests plus buffered words must leave room for every granted response.
  assign credit_ok  = ({1'b0, outst_q} + {1'b0, count_q}) < DEPTH_V;
  assign start_ok   = (state_q == IDLE) && start_i;
  assign gnt_fire   = req && bus.mst_gnt_i;
  assign push       = bus.mst_rvalid_i && (outst_q != '0);
  assign valid      = (count_q != '0);
  assign pop        = valid && bus.ready_i;
  // The final pop counts as drained so done follows it by exactly one cycle.
  assign drain_done = (outst_q == '0) && ((count_q == '0) || ((count_q == CW'(1)) && pop));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and request generation
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = (len_i != '0) ? REQ : DRAIN;
      end
      REQ: begin
        req = credit_ok && (rem_q != '0);
        if (req && bus.mst_gnt_i && (rem_q == LEN_WIDTH'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address and remaining-word counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (start_ok) begin
      addr_q <= {src_addr_i[31:2], 2'b00};
      rem_q  <= len_i;
    end else if (gnt_fire) begin
      addr_q <= addr_q + 32'd4;
      rem_q  <= rem_q - LEN_WIDTH'(1);
    end
  end

  // Granted-but-unanswered request count; responses arriving at zero are stale
  always_ff @(posedge clk_i) begin
    if (rst_i) outst_q <= '0;
    else begin
      case ({gnt_fire, push})
        2'b10:   outst_q <= outst_q + CW'(1);
        2'b01:   outst_q <= outst_q - CW'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.mst_rdata_i;
  end

  // Completion pulse one cycle after the drain condition
  always_ff @(posedge clk_i) begin
    if (rst_i) done_q <= 1'b0;
    else       done_q <= (state_q == DRAIN) && drain_done;
  end

`ifdef EXT_MEM_READER_CHECKSUM_EN
  logic [31:0] csum_q;
  // Running XOR of popped words, restarted by each accepted start
  always_ff @(posedge clk_i) begin
    if (rst_i || start_ok) csum_q <= '0;
    else if (pop)          csum_q <= csum_q ^ bus.data_o;
  end
  assign checksum_o = csum_q;
`endif

  assign busy_o          = (state_q != IDLE);
  assign done_o          = done_q;
  assign bus.mst_req_o   = req;
  assign bus.mst_addr_o  = addr_q;
  assign bus.mst_we_o    = 1'b0;
  assign bus.mst_be_o    = 4'hF;
  assign bus.mst_wdata_o = 32'h0;
  assign bus.valid_o     = valid;
  assign bus.data_o      = valid ? mem_q[rd_ptr_q] : 32'h0;

endmodule

// File: doc/ext_mem_reader.md
# ext_mem_reader

OBI master that reads a contiguous block of 32-bit words from X-HEEP memory through the SoC's external master crossbar port and streams them to a local consumer over a valid/ready interface. It is the initiator side of the external-slave address map: IPs in the SoC use it to pull data out of X-HEEP memory. Response data passes through an internal FIFO. A credit scheme guarantees the FIFO never overflows while requests are outstanding.

## Interface
Parameters:
- FIFO_DEPTH, 4, response FIFO entries; power of two, ≥2.
- LEN_WIDTH, 16, width of the word-count input.

Ports:
- clk_i  in  1  clock; one clock domain only.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  start pulse; sampled only in IDLE.
- src_addr_i  in  32  byte start address; bits [1:0] forced to 0 on latch.
- len_i  in  LEN_WIDTH  number of words to read.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle completion pulse.
- mst_req_o  out  1  OBI request.
- mst_gnt_i  in  1  OBI grant.
- mst_addr_o  out  32  OBI address.
- mst_we_o  out  1  constant 0.
- mst_be_o  out  4  constant 4'hF.
- mst_wdata_o  out  32  constant 0.
- mst_rvalid_i  in  1  OBI response valid; responses arrive in order.
- mst_rdata_i  in  32  OBI response data.
- data_o  out  32  stream data.
- valid_o  out  1  stream valid.
- ready_i  in  1  stream ready.

## Operation
- FSM states: IDLE, REQ, DRAIN.
- IDLE:
  - start_i latches the address and len_i.
  - len≠0: go to REQ.
  - len=0: go to DRAIN with nothing pending.
  - start_i in REQ or DRAIN is ignored.
- Credits:
  - outstanding = grants minus rvalids, counted over the current transfer.
  - mst_req_o may rise only when outstanding + FIFO occupancy < FIFO_DEPTH and remaining > 0.
  - Once raised, mst_req_o holds, with mst_addr_o stable, until mst_gnt_i. Credits are only released by stream pops, so the request never has to be withdrawn.
- On req && gnt:
  - address += 4, wrapping modulo 2^32.
  - remaining −= 1.
  - When remaining reaches 0, go to DRAIN.
- On mst_rvalid_i with outstanding > 0: push mst_rdata_i into the FIFO. rvalid with outstanding = 0 is dropped (stale response).
- Stream side:
  - valid_o = FIFO not empty.
  - Pop on valid_o && ready_i.
  - data_o must stay stable while valid_o && !ready_i.
- DRAIN completes when outstanding = 0 and the FIFO is empty. The next cycle: done_o = 1, busy_o = 0, state returns to IDLE.
- Simultaneous FIFO push and pop in the same cycle is legal, including when the FIFO is full or empty.
- Reset mid-operation:
  - FSM, counters and FIFO are cleared.
  - Responses still in flight are dropped by the outstanding = 0 rule.
- Reset values:
  - All outputs 0, except mst_be_o = 4'hF.
  - State IDLE.

## Timing
- start_i at cycle 0 → mst_req_o earliest at cycle 1.
- mst_rvalid_i at cycle N → valid_o earliest at cycle N+1 (registered FIFO output).
- Sustains 1 word/cycle when FIFO_DEPTH ≥ 3, gnt is continuous, rvalid follows gnt by 1 cycle, and ready_i = 1.
- Last stream pop at cycle M → done_o at cycle M+1.
- len=0: start at cycle 0 → done_o at cycle 2; no OBI activity.

## Configuration
- EXT_MEM_READER_CHECKSUM_EN defined:
  - Adds output port checksum_o [31:0].
  - checksum_o is the XOR of all words popped on the stream in the current transfer.
  - It is cleared to 0 on an accepted start and on reset, and stays valid after done_o until the next start.
- EXT_MEM_READER_CHECKSUM_EN undefined: the port and its logic are absent.

## Test plan
- Basic read:
  - Stimulus: len=3, addr 0x100, memory returns data = address, gnt always, ready_i=1.
  - Response: data_o sequence 0x100, 0x104, 0x108; exactly one done_o pulse; checksum_o=0x10C when EXT_MEM_READER_CHECKSUM_EN is defined.
- Zero length:
  - Stimulus: len=0.
  - Response: mst_req_o never asserted; done_o at cycle 2; busy_o high only in cycle 1.
- Backpressure:
  - Stimulus: FIFO_DEPTH=4, len=8, ready_i=0.
  - Response: exactly 4 grants, then mst_req_o low. Raising ready_i resumes the transfer; all 8 words arrive in order, none lost or duplicated.
- Delayed grant:
  - Stimulus: gnt withheld for 3 cycles.
  - Response: mst_req_o and mst_addr_o stable for all 4 cycles; one transaction recorded.
- Address wrap:
  - Stimulus: addr 0xFFFFFFFE, len=2.
  - Response: addresses 0xFFFFFFFC, then 0x00000000.
- Reset mid-transfer:
  - Stimulus: rst_i after 2 grants, with rvalid arriving in the reset cycle +1.
  - Response: all outputs at reset values; the late response is not streamed; a subsequent start with len=1 completes normally.
